// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal around the unified-memory arbiter except clock and
// reset: the instruction-fetch requester port, the data requester port, the
// memory-side port and the pipeline stall output.
//   slave  : view taken by the arbiter itself
//   master : view taken by the surrounding requesters / memory model
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    // data load/store port
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              err_o;
    // memory port
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    // pipeline stall
    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ready_i,
        output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_rdata_i, mem_ready_i,
        input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between instruction fetch
// (IF) and data load/store (D). Each transaction runs IDLE -> BUSY -> ACK.
// Ties are broken in favour of the port that was not granted last. A watchdog
// aborts a BUSY phase after TIMEOUT cycles without mem_ready_i (TIMEOUT=0
// disables it) and flags err_o alongside the ack.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : mem_port_arbiter_if.slave (IF port, D port, memory port,
//                  combinational stall_o)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_D   = 1'b1;
    // Last counter value before the watchdog fires; guarded by TIMEOUT != 0.
    localparam int   TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_d_port;
    logic                timeout_hit;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        // acks and err are single-cycle pulses: they only live in ACK
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant_d_port = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req_i || bus.d_req_i) begin
                    if (bus.if_req_i && bus.d_req_i) begin
                        grant_d_port = (last_grant_q == OWN_IF);
                    end else begin
                        grant_d_port = bus.d_req_i;
                    end
                    owner_d      = grant_d_port ? OWN_D : OWN_IF;
                    last_grant_d = grant_d_port ? OWN_D : OWN_IF;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    state_d      = ST_BUSY;
                    if (grant_d_port) begin
                        mem_we_d    = bus.d_we_i;
                        mem_addr_d  = bus.d_addr_i;
                        mem_wdata_d = bus.d_wdata_i;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end

            ST_BUSY: begin
                timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))
                              && !bus.mem_ready_i;
                // ready takes precedence over a coincident timeout
                if (bus.mem_ready_i) begin
                    state_d   = ST_ACK;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata_i;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_ACK;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.err_o       = err_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_ack_q) | (bus.d_req_i & ~d_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-ported unified memory between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between PC/Instruction_Memory-side fetch logic, the Data_Memory-side access logic, and a memory with variable latency.
- Arbitrates between the two requesters and runs a per-transaction state machine with a timeout watchdog.
- Produces a pipeline stall signal while any request is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum BUSY cycles before abort. 0 disables the watchdog.
- CNT_W, 8, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  DATA_W  fetched instruction; valid when if_ack_o is high.
- d_req_i  in  1  data request; held high until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_ack_o  out  1  one-cycle data completion pulse.
- d_rdata_o  out  DATA_W  load data; valid when d_ack_o is high.
- err_o  out  1  high together with an ack when that transaction timed out.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data; sampled when mem_ready_i is high.
- mem_ready_i  in  1  memory completion; meaningful only in BUSY.
- stall_o  out  1  combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, owner=IF, last_grant=IF, wait counter=0.
  - All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, acks, rdata outputs, err_o.
  - Any in-flight transaction is discarded with no ack.
- States:
  - IDLE -> BUSY when any request is present.
  - BUSY -> ACK on mem_ready_i, or on timeout.
  - ACK -> IDLE unconditionally.
- Arbitration (IDLE only):
  - A single requester wins.
  - If both request, the requester not equal to last_grant wins. After reset, D wins the first tie.
  - On grant: latch owner; update last_grant; register mem_addr_o/mem_we_o/mem_wdata_o from the winner; clear the wait counter.
  - mem_we_o=0 and mem_wdata_o=0 for IF grants.
- BUSY:
  - mem_req_o=1; address, we and wdata held constant.
  - Wait counter increments each cycle in which mem_ready_i=0.
  - mem_ready_i=1: capture mem_rdata_i into the owner's rdata register (loads and fetches only; stores leave d_rdata_o unchanged), then go to ACK.
  - Timeout: TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready_i=0 on that edge.
    - Go to ACK with err_o set; the owner's rdata register is loaded with 0.
    - Transaction latency = TIMEOUT BUSY cycles.
  - If mem_ready_i and timeout coincide, ready wins: normal completion, err_o=0.
- ACK:
  - mem_req_o=0.
  - Owner's ack=1 for exactly this cycle; err_o as determined in BUSY; both clear the next cycle.
  - Requester drops its request or changes its payload at the end of the ACK cycle. Requests are not sampled in ACK.
- Minimum transaction latency: grant edge, BUSY with ready in the first cycle, ACK. Request to ack = 2 cycles. Back-to-back throughput = 1 transaction per 3 cycles.
- mem_ready_i in IDLE or ACK: ignored.
- A requester dropping its request during BUSY is a protocol violation. The transaction still completes and the ack still fires.
- rdata outputs hold their value until the next completion for the same port.

Test Plan:
- Reset then IF-only read:
  - Stimulus: if_addr=0x0000_0004; memory ready 1 cycle after mem_req with rdata=0x2002_0005.
  - Required: mem_req_o high 1 cycle with mem_addr=0x4, mem_we=0; if_ack_o pulses 2 cycles after request with if_rdata_o=0x2002_0005; stall_o high until ack.
- Simultaneous request after reset:
  - Stimulus: IF addr 0x8; D store addr 0x20, wdata 0xDEAD_BEEF.
  - Required: D granted first (mem_we=1, wdata=0xDEAD_BEEF); IF granted next; d_ack precedes if_ack by 3 cycles; d_rdata_o stays 0.
- Fairness:
  - Stimulus: both hold requests for 4 transactions.
  - Required: grant order D, IF, D, IF; no port is granted twice in a row while the other waits.
- Timeout:
  - Stimulus: TIMEOUT=4, D load, mem_ready_i never asserted.
  - Required: mem_req_o high exactly 4 cycles; d_ack_o=1 and err_o=1 in the same cycle; d_rdata_o=0.
  - Variant: ready on the 4th cycle gives err_o=0.
- Reset mid-BUSY:
  - Stimulus: assert rst_i between clock edges while BUSY.
  - Required: mem_req_o falls immediately; no ack is issued; after release, a pending IF request is granted normally.
- Spurious mem_ready_i:
  - Stimulus: pulse mem_ready_i during IDLE and ACK.
  - Required: no state change, no extra ack, rdata unchanged.
